fp_stream_accumulator: RTL and testbench

//  Sequential front/back-end for FloatingPointAdder: sums a stream of LEN IEEE-754 single-precision words.

---
 rtl/fp_stream_accumulator.sv | 99 +++++++++
 tb/tb_fp_stream_accumulator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_stream_accumulator.sv
// rtl/fp_stream_accumulator.sv - sequential wrapper summing a stream of LEN float words via an external adder
module fp_stream_accumulator #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      acc, acc_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [LEN_W-1:0] len_q, len_q_nxt;
    logic             ovf_q, ovf_nxt;
    logic             beat;
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= 32'h0;
            cnt   <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            len_q <= len_q_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    assign beat = (state == ACC) && in_valid;
    // Exit compares against len_q-1 so cnt never needs to hold len_q itself.
    assign last = (cnt == len_q - LEN_W'(1));

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        len_q_nxt = len_q;
        ovf_nxt   = ovf_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt   = 32'h0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    len_q_nxt = len;
                    state_nxt = (len == '0) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_nxt = add_sum;
                    cnt_nxt = cnt + LEN_W'(1);
                    ovf_nxt = ovf_q | (add_sum[30:23] == 8'hFF);
                    if (last) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign out_data  = acc;
    assign ovf       = ovf_q;
    assign add_a     = acc;
    assign add_b     = in_data;

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// tb/tb_fp_stream_accumulator.sv - directed bench for fp_stream_accumulator with a positive-only float adder model
module tb_fp_stream_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        ovf;
    logic        busy;

    int n_vec;
    int n_err;

    fp_stream_accumulator #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating adder for non-negative normals/zero; saturates to +inf on exponent overflow.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [8:0]  e;
        logic [24:0] mx, my, m;
        int          d;
        if (a == 32'h0) return b;
        if (b == 32'h0) return a;
        if (a[30:23] >= b[30:23]) begin x = a; y = b; end
        else begin x = b; y = a; end
        d  = int'(x[30:23]) - int'(y[30:23]);
        mx = {2'b01, x[22:0]};
        my = (d > 24) ? 25'h0 : ({2'b01, y[22:0]} >> d);
        m  = mx + my;
        e  = {1'b0, x[30:23]};
        if (m[24]) begin
            m = m >> 1;
            e = e + 9'd1;
        end
        if (e >= 9'd255) return 32'h7F800000;
        return {1'b0, e[7:0], m[22:0]};
    endfunction

    always_comb add_sum = fp_add(add_a, add_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready",  32'(in_ready),  32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst ovf",       32'(ovf),       32'd0);
        check("rst out_data",  out_data,       32'h0);
        rst_n = 1'b1;
        tick();

        // len=3 back-to-back; len changed after start must be ignored
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0; len = 8'd7;
        check("acc in_ready", 32'(in_ready), 32'd1);
        check("acc busy",     32'(busy),     32'd1);
        in_data = 32'h12345678;
        #1 check("add_b passthru", add_b, 32'h12345678);
        feed(32'h3F800000);
        check("acc add_a", add_a, 32'h3F800000);
        feed(32'h40000000);
        feed(32'h40400000);
        in_valid = 1'b0;
        check("sum3 out_valid", 32'(out_valid), 32'd1);
        check("sum3 out_data",  out_data,       32'h40C00000);
        check("sum3 in_ready",  32'(in_ready),  32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sum3 done valid", 32'(out_valid), 32'd0);
        check("sum3 done busy",  32'(busy),      32'd0);
        check("idle keeps data", out_data,       32'h40C00000);

        // len=0 goes straight to HOLD with +0.0
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        check("len0 out_valid", 32'(out_valid), 32'd1);
        check("len0 out_data",  out_data,       32'h0);
        check("len0 in_ready",  32'(in_ready),  32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("len0 done", 32'(out_valid), 32'd0);

        // len=2 with gaps, then back-pressure for 5 cycles
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        tick();
        check("gap no advance", 32'(out_valid), 32'd0);
        feed(32'h3F800000);
        in_valid = 1'b0;
        tick();
        tick();
        check("gap in_ready", 32'(in_ready), 32'd1);
        feed(32'h40000000);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold out_data",  out_data,       32'h40400000);
            check("hold in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold release", 32'(out_valid), 32'd0);

        // exponent overflow sets sticky ovf; cleared on next start
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        feed(32'h7F000000);
        check("ovf not yet", 32'(ovf), 32'd0);
        feed(32'h7F000000);
        in_valid = 1'b0;
        check("ovf out_valid", 32'(out_valid), 32'd1);
        check("ovf flag",      32'(ovf),       32'd1);
        check("ovf out_data",  out_data,       32'h7F800000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ovf sticky idle", 32'(ovf), 32'd1);
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        check("ovf cleared", 32'(ovf), 32'd0);
        feed(32'h3F800000);
        in_valid = 1'b0;
        check("len1 out_valid", 32'(out_valid), 32'd1);
        check("len1 out_data",  out_data,       32'h3F800000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // start while busy ignored; reset mid-stream aborts
        start = 1'b1; len = 8'd3;
        tick();
        len = 8'd1;
        feed(32'h40000000);
        start = 1'b0;
        in_valid = 1'b0;
        check("restart ignored busy", 32'(busy),      32'd1);
        check("restart ignored rdy",  32'(in_ready),  32'd1);
        check("partial acc",          add_a,          32'h40000000);
        #2 rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort busy",      32'(busy),      32'd0);
        check("abort in_ready",  32'(in_ready),  32'd0);
        check("abort out_data",  out_data,       32'h0);
        #1 rst_n = 1'b1;
        tick();
        tick();
        check("post abort valid", 32'(out_valid), 32'd0);
        check("post abort busy",  32'(busy),      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
